// File: rtl/iob_uart_txfifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and
// default sizing constants.
package iob_uart_txfifo_pkg;

    // Drain FSM states; encoding is visible to debug tooling, keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } txfifo_state_e;

    localparam int TXFIFO_DEPTH_LOG2_DEF = 4;
    localparam int TXFIFO_GUARD_CYC_DEF  = 2;

endpackage

// File: rtl/iob_uart_txfifo_mem.sv
// Character storage for the UART transmit FIFO: synchronous write port,
// asynchronous read port, no reset (contents are qualified by the pointers).
module iob_uart_txfifo_mem #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    // Write the pushed character into its slot.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/iob_uart_txfifo.sv
// UART transmit FIFO: buffers CPU writes and drains them one character at a
// time into uart_core, issuing a single-cycle write pulse whenever the core is
// ready. Optional sticky overflow flag enabled by IOB_UART_TXFIFO_OVF_EN.
module iob_uart_txfifo
    import iob_uart_txfifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = TXFIFO_DEPTH_LOG2_DEF,
    parameter int GUARD_CYC  = TXFIFO_GUARD_CYC_DEF
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  soft_rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  core_ready_i,
    output logic                  core_wen_o,
    output logic [DATA_W-1:0]     core_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    input  logic                  ovf_clr_i
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam int GW = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC + 1);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] head_data;
    logic [GW-1:0]     guard_q, guard_d;
    txfifo_state_e     state_q, state_d;
    logic              push;
    logic              pop;

    // Occupancy flags come straight from the registered pointers; the wrap
    // bit distinguishes full from empty when the low bits match.
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                        (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign wr_ready_o = !full_o && !soft_rst_i;
    assign push       = wr_en_i && wr_ready_o;
    assign core_wen_o = (state_q == ST_ISSUE);
    assign core_data_o = data_q;

    iob_uart_txfifo_mem #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk_i    (clk_i),
        .wr_en_i  (push),
        .wr_addr_i(wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i(wr_data_i),
        .rd_addr_i(rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o(head_data)
    );

    // Drain FSM next state: pop in IDLE, pulse in ISSUE, then wait for the
    // core to acknowledge (ready low, or guard expiry) and to become ready.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        pop     = 1'b0;
        if (soft_rst_i) begin
            state_d = ST_IDLE;
            guard_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_o && core_ready_i) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT_LOW;
                    guard_d = GW'(GUARD_CYC);
                end
                ST_WAIT_LOW: begin
                    if (!core_ready_i || guard_q <= GW'(1)) begin
                        state_d = ST_WAIT_HIGH;
                    end else begin
                        guard_d = guard_q - GW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (core_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pointer and output-data next state; soft reset flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        data_d   = pop ? head_data : data_q;
        if (soft_rst_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            data_d   = '0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= ST_IDLE;
            guard_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
        end
    end

`ifdef IOB_UART_TXFIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a rejected push sets it and wins over a clear.
    always_comb begin
        ovf_d = ovf_q;
        if (soft_rst_i) begin
            ovf_d = 1'b0;
        end else if (wr_en_i && full_o) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign overflow_o     = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart_txfifo.sv
// Directed bench for iob_uart_txfifo: a cycle-by-cycle vector table followed
// by hand-written multi-cycle scenarios with a simple uart_core ready model.
module tb_iob_uart_txfifo;

`ifdef IOB_UART_TXFIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif
    localparam int GUARD = 2;

    logic       clk;
    logic       arst_n;
    logic       soft_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       core_ready;
    logic       core_wen;
    logic [7:0] core_data;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       ovf_clr;

    iob_uart_txfifo #(
        .DATA_W    (8),
        .DEPTH_LOG2(4),
        .GUARD_CYC (GUARD)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .soft_rst_i  (soft_rst),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .core_ready_i(core_ready),
        .core_wen_o  (core_wen),
        .core_data_o (core_data),
        .level_o     (level),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .ovf_clr_i   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wd;
        logic       rdy;
        logic       srst;
        logic       wen;
        logic [7:0] dat;
        logic [4:0] lvl;
        logic       emp;
        logic       ful;
        logic       wrdy;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // core model and capture state
    logic       model_en = 1'b0;
    int         busy = 0;
    int         tick_no = 0;
    int         wen_cnt = 0;
    int         dbl_cnt = 0;
    logic       prev_wen = 1'b0;
    logic [7:0] rx_q[$];
    int         wen_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample #1 after the edge, log write pulses, run ready model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (core_wen) begin
            if (prev_wen) dbl_cnt++;
            rx_q.push_back(core_data);
            wen_t.push_back(tick_no);
            wen_cnt++;
            if (model_en) begin
                core_ready = 1'b0;
                busy = 10;
            end
        end else if (model_en && busy > 0) begin
            busy--;
            if (busy == 0) core_ready = 1'b1;
        end
        prev_wen = core_wen;
        tick_no++;
    endtask

    task automatic clear_log();
        rx_q.delete();
        wen_t.delete();
        wen_cnt = 0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (wen_cnt < n && b < budget) begin
            tick();
            b++;
        end
        chk(name, 32'(wen_cnt), 32'(n));
    endtask

    task automatic do_reset();
        wr_en = 1'b0; wr_data = '0; soft_rst = 1'b0; ovf_clr = 1'b0;
        core_ready = 1'b0; model_en = 1'b0; busy = 0;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        prev_wen = 1'b0;
        clear_log();
    endtask

    vec_t tbl[11];

    initial begin
        arst_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; soft_rst = 1'b0; ovf_clr = 1'b0; core_ready = 1'b0;

        // ---- reset values ----
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wrready", 32'(wr_ready), 32'd1);
        chk("rst_wen", 32'(core_wen), 32'd0);
        chk("rst_data", 32'(core_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // ---- table: single character, short queue, soft reset in ISSUE ----
        //            wr  wd     rdy srst  wen dat    lvl  emp ful wrdy
        tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h41, 5'd2, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            wr_en = tbl[i].wr_en; wr_data = tbl[i].wd;
            core_ready = tbl[i].rdy; soft_rst = tbl[i].srst;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), 32'(core_wen), 32'(tbl[i].wen));
            chk($sformatf("v%0d_data", i), 32'(core_data), 32'(tbl[i].dat));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].ful));
            chk($sformatf("v%0d_wrready", i), 32'(wr_ready), 32'(tbl[i].wrdy));
        end
        wr_en = 1'b0; soft_rst = 1'b0;

        // ---- async reset mid-drain ----
        do_reset();
        core_ready = 1'b1;
        push(8'h33);
        tick();
        chk("mid_wen_before_rst", 32'(core_wen), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("arst_wen", 32'(core_wen), 32'd0);
        chk("arst_data", 32'(core_data), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 arst_n = 1'b1;
        clear_log();
        repeat (10) tick();
        chk("arst_no_wen_after", 32'(wen_cnt), 32'd0);

        // ---- burst of 16, overflow, drain with busy core model ----
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("burst_level", 32'(level), 32'd16);
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_wrready", 32'(wr_ready), 32'd0);
        chk("burst_ovf_pre", 32'(overflow), 32'd0);
        push(8'hFF);
        chk("ovf_set", 32'(overflow), 32'(OVF_EXP));
        chk("ovf_level", 32'(level), 32'd16);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        ovf_clr = 1'b1; push(8'hFE); ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'(OVF_EXP));
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);
        model_en = 1'b1; core_ready = 1'b1; busy = 0;
        drain(16, 600, "burst_count");
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("burst_char%0d", i), 32'(rx_q[i]), 32'(i));
        repeat (15) tick();
        chk("burst_no_extra", 32'(wen_cnt), 32'd16);
        chk("burst_empty", 32'(empty), 32'd1);

        // ---- wrapped pointers, simultaneous push and pop ----
        model_en = 1'b0; core_ready = 1'b0; busy = 0;
        clear_log();
        for (int i = 0; i < 15; i++) push(8'(8'h20 + i));
        chk("wrap_level15", 32'(level), 32'd15);
        model_en = 1'b1; core_ready = 1'b1; busy = 0;
        push(8'hA5);
        chk("pushpop_level", 32'(level), 32'd15);
        drain(16, 600, "wrap_count");
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("wrap_char%0d", i), 32'(rx_q[i]),
                (i == 15) ? 32'hA5 : 32'(8'h20 + i));
        repeat (15) tick();

        // ---- soft reset during ISSUE with level 5 ----
        model_en = 1'b0; core_ready = 1'b0; busy = 0;
        clear_log();
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        core_ready = 1'b1;
        tick();
        chk("srst_issue_wen", 32'(core_wen), 32'd1);
        chk("srst_issue_level", 32'(level), 32'd5);
        soft_rst = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();
        chk("srst_level", 32'(level), 32'd0);
        chk("srst_data", 32'(core_data), 32'd0);
        chk("srst_wen", 32'(core_wen), 32'd0);
        chk("srst_wrready", 32'(wr_ready), 32'd0);
        chk("srst_ovf", 32'(overflow), 32'd0);
        soft_rst = 1'b0; wr_en = 1'b0;
        clear_log();
        repeat (20) tick();
        chk("srst_no_wen", 32'(wen_cnt), 32'd0);
        chk("srst_wrready_after", 32'(wr_ready), 32'd1);
        push(8'h66);
        chk("srst_push_level", 32'(level), 32'd1);
        drain(1, 20, "srst_push_count");
        if (rx_q.size() > 0) chk("srst_push_char", 32'(rx_q[0]), 32'h66);

        // ---- ready never drops: guard-limited spacing ----
        do_reset();
        core_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        repeat (20) tick();
        chk("guard_count", 32'(wen_cnt), 32'd3);
        for (int i = 1; i < 3 && i < wen_t.size(); i++)
            chk($sformatf("guard_spacing%0d", i), 32'(wen_t[i] - wen_t[i-1]), 32'(GUARD + 3));
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            chk($sformatf("guard_char%0d", i), 32'(rx_q[i]), 32'(i + 1));

        chk("wen_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
